// File: rtl/dclab_pkg.sv
// Shared definitions for the DCLab input-conditioning blocks.
//   key_state_e             : debouncer FSM state encoding (2 bits)
//   DefDebounceCycles       : default debounce window (20 ms at 50 MHz)
//   DefLongPressCycles      : default long-press threshold (1 s at 50 MHz)
package dclab_pkg;

    typedef enum logic [1:0] {
        StReleased   = 2'd0,
        StPressChk   = 2'd1,
        StPressed    = 2'd2,
        StReleaseChk = 2'd3
    } key_state_e;

    localparam int unsigned DefDebounceCycles  = 1_000_000;
    localparam int unsigned DefLongPressCycles = 50_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset; both flops load ResetVal
//   i_d     : asynchronous input
//   o_q     : synchronized output (two destination-clock edges of latency)
module sync_2ff #(
    parameter int unsigned      Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer with press/release/long-press event pulses.
//   i_clk     : clock, rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_key_n   : raw bouncing key, 0 = pressed
//   o_start   : one-cycle pulse when a press is accepted
//   o_pressed : debounced level, 1 = pressed
//   o_release : one-cycle pulse when a release is accepted
//   o_long    : one-cycle pulse once a press has been held LONG_PRESS_CYCLES
// All outputs are registered.
module key_debounce
    import dclab_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DefDebounceCycles,
    parameter int unsigned LONG_PRESS_CYCLES = DefLongPressCycles
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_start,
    output logic o_pressed,
    output logic o_release,
    output logic o_long
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HoldW = $clog2(LONG_PRESS_CYCLES);

    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_PRESS_CYCLES - 1);

    logic key_s;

    // Idle level of the key is high (released), so the synchronizer resets to 1.
    sync_2ff #(
        .Width    (1),
        .ResetVal (1'b1)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_key_n),
        .o_q     (key_s)
    );

    key_state_e       state_q, state_d;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             long_done_q, long_done_d;
    logic             long_fire;

    logic start_q, start_d;
    logic pressed_q, pressed_d;
    logic release_q, release_d;
    logic long_q, long_d;

    // State and counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StReleased;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
        end
    end

    // Long press fires on the first cycle the saturated hold count is seen.
    assign long_fire = (hold_cnt_q == HoldLast) && !long_done_q;

    // Next-state and counter logic.
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;

        if (long_fire) begin
            long_done_d = 1'b1;
        end

        unique case (state_q)
            StReleased: begin
                db_cnt_d = '0;
                if (!key_s) begin
                    state_d = StPressChk;
                end
            end
            StPressChk: begin
                if (key_s) begin
                    state_d  = StReleased;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DbLast) begin
                    state_d     = StPressed;
                    db_cnt_d    = '0;
                    hold_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            StPressed: begin
                if (key_s) begin
                    state_d  = StReleaseChk;
                    db_cnt_d = '0;
                end else if (hold_cnt_q != HoldLast) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StReleaseChk: begin
                // A bounce back to pressed resumes the hold without a new start.
                if (!key_s) begin
                    state_d  = StPressed;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DbLast) begin
                    state_d  = StReleased;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = StReleased;
                db_cnt_d = '0;
            end
        endcase
    end

    // Output decode from the transition being taken, so the registered
    // outputs line up with the state register.
    always_comb begin
        start_d   = (state_q == StPressChk) && (state_d == StPressed);
        release_d = (state_q == StReleaseChk) && (state_d == StReleased);
        pressed_d = (state_d == StPressed) || (state_d == StReleaseChk);
        long_d    = long_fire;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            start_q   <= 1'b0;
            pressed_q <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            start_q   <= start_d;
            pressed_q <= pressed_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign o_start   = start_q;
    assign o_pressed = pressed_q;
    assign o_release = release_q;
    assign o_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES = 4, LONG_PRESS_CYCLES = 16.
module tb_key_debounce;

    logic clk;
    logic rst_n;
    logic key_n;
    logic o_start;
    logic o_pressed;
    logic o_release;
    logic o_long;

    int n_checks;
    int n_fail;

    key_debounce #(
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (16)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_key_n   (key_n),
        .o_start   (o_start),
        .o_pressed (o_pressed),
        .o_release (o_release),
        .o_long    (o_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_low(input string tag);
        chk({tag, "_start"}, o_start, 1'b0);
        chk({tag, "_pressed"}, o_pressed, 1'b0);
        chk({tag, "_release"}, o_release, 1'b0);
        chk({tag, "_long"}, o_long, 1'b0);
    endtask

    initial begin
        logic [3:0] bounce;
        int         long_seen;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        key_n    = 1'b1;

        // Reset state, before and after clocks arrive.
        #1;
        chk_all_low("rst_async");
        tick();
        tick();
        chk_all_low("rst_clocked");
        rst_n = 1'b1;
        repeat (3) tick();
        chk_all_low("idle");

        // Clean press: start 6 edges after first low sample, long 16 after start.
        key_n = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            chk("press_start", o_start, i == 7);
            chk("press_pressed", o_pressed, i >= 7);
            chk("press_long", o_long, i == 23);
            chk("press_release", o_release, 1'b0);
        end

        // Two-cycle release glitch while held: nothing changes.
        for (int i = 1; i <= 14; i++) begin
            if (i == 1) key_n = 1'b1;
            if (i == 3) key_n = 1'b0;
            tick();
            chk("glitch_pressed", o_pressed, 1'b1);
            chk("glitch_start", o_start, 1'b0);
            chk("glitch_release", o_release, 1'b0);
            chk("glitch_long", o_long, 1'b0);
        end

        // Clean release.
        key_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("rel_release", o_release, i == 7);
            chk("rel_pressed", o_pressed, i < 7);
            chk("rel_start", o_start, 1'b0);
        end

        // Bounce 0,1,0,1 then stable 0: start 6 edges after the final 0 sample.
        bounce = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            key_n = bounce[i];
            tick();
            chk("bounce_start", o_start, 1'b0);
            chk("bounce_pressed", o_pressed, 1'b0);
        end
        key_n = 1'b0;
        tick();
        chk("bounce_last_start", o_start, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("bounce_start_after", o_start, i == 6);
            chk("bounce_pressed_after", o_pressed, i >= 6);
            chk("bounce_release_after", o_release, 1'b0);
        end
        repeat (3) tick();

        // Reset mid-hold clears at once, with no release pulse.
        rst_n = 1'b0;
        #1;
        chk_all_low("midrst_async");
        tick();
        tick();
        chk_all_low("midrst_clocked");
        rst_n = 1'b1;

        // Key still held: fresh press, then a long hold with a single long pulse.
        long_seen = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            chk("hold_start", o_start, i == 7);
            chk("hold_pressed", o_pressed, i >= 7);
            chk("hold_long", o_long, i == 23);
            chk("hold_release", o_release, 1'b0);
            if (o_long === 1'b1) long_seen++;
        end
        chk_int("hold_long_count", long_seen, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
